seg595_scan_n: RTL and testbench

- Parametrised multi-digit 7-segment scan driver for a daisy-chained 74HC595 segment/select register pair.
- Accepts a binary value on a valid strobe and converts it to BCD with a sequential double-dabble converter.
- Applies leading-zero blanking, sign, decimal points, overflow dashes and PWM brightness.
- Serialises one digit per scan slot into the 595 chain; sits between application logic and the board display pins.

---
 rtl/seg595_pkg.sv | 47 ++++
 rtl/bin2bcd_seq.sv | 76 +++++++
 rtl/seg595_scan_n.sv | 265 ++++++++++++++++++++++++++
 tb/tb_seg595_scan_n.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg595_pkg.sv
// seg595_pkg: shared constants and helpers for the 74HC595 7-segment scan driver.
//   - SEG_* : active-low segment codes, bit7 = dp, bits6..0 = g..a
//   - shift_state_t : shift/latch sequencer state encoding
//   - frame_bits() : number of bits shifted per scan slot (segment byte + selects)
//   - seg_code() : BCD digit to active-low segment code
package seg595_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } shift_state_t;

  function automatic int frame_bits(input int digits);
    return 8 + digits;
  endfunction

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary to BCD converter.
//   clk, rst : clock, asynchronous active-high reset (aborts a conversion)
//   start    : accepted only while busy=0; captures bin
//   bin      : unsigned binary input
//   busy     : high from the cycle after start until the finish cycle ends
//   done     : high during the finish cycle (after DATA_W shift cycles)
//   bcd      : NDIG packed BCD digits, digit 0 in bits 3:0, valid while done=1
//   lost     : a BCD carry fell off the top digit (value exceeds NDIG digits)
module bin2bcd_seq #(
  parameter int DATA_W = 20,
  parameter int NDIG   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] bin,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] bcd,
  output logic              lost
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] sh_q;
  logic [4*NDIG-1:0] bcd_q;
  logic [4*NDIG-1:0] bcd_adj;
  logic              lost_q;
  logic              shift_en;

  assign done     = busy_q && (cnt_q == CNT_W'(DATA_W));
  assign shift_en = busy_q && (cnt_q != CNT_W'(DATA_W));

  // Add 3 to every digit >= 5 before the shift so it carries correctly.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (!busy_q) begin
      if (start) begin
        busy_q <= 1'b1;
        cnt_q  <= '0;
      end
    end else if (done) begin
      busy_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!busy_q && start) begin
      sh_q   <= bin;
      bcd_q  <= '0;
      lost_q <= 1'b0;
    end else if (shift_en) begin
      bcd_q  <= {bcd_adj[4*NDIG-2:0], sh_q[DATA_W-1]};
      sh_q   <= sh_q << 1;
      lost_q <= lost_q | bcd_adj[4*NDIG-1];
    end
  end

  assign busy = busy_q;
  assign bcd  = bcd_q;
  assign lost = lost_q;

endmodule

// File: rtl/seg595_scan_n.sv
// seg595_scan_n: multi-digit 7-segment scan driver for a daisy-chained
// 74HC595 segment/select register pair.
//   sys_clk, sys_rst : clock, asynchronous active-high reset
//   data_vld, data   : load strobe and unsigned value (ignored while busy)
//   point, sign      : per-digit decimal points, minus sign (captured with data)
//   seg_en, bright   : display enable and 4-bit PWM brightness
//   busy, ovf        : conversion running, value does not fit the display
//   shcp, stcp, ds   : 595 shift clock, latch clock, serial data
//   oe               : 595 output enable, active low (PWM brightness)
// Each scan slot shifts {seg[7:0], sel[DIGITS-1:0]} MSB first, then latches.
module seg595_scan_n
  import seg595_pkg::*;
#(
  parameter int DIGITS         = 6,
  parameter int DATA_W         = 20,
  parameter int SCAN_DIV       = 50000,
  parameter int SHCP_HALF      = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              data_vld,
  input  logic [DATA_W-1:0] data,
  input  logic [DIGITS-1:0] point,
  input  logic              sign,
  input  logic              seg_en,
  input  logic [3:0]        bright,
  output logic              busy,
  output logic              ovf,
  output logic              shcp,
  output logic              stcp,
  output logic              ds,
  output logic              oe
);

  localparam int FB     = frame_bits(DIGITS);
  localparam int NDIG   = DIGITS + 1;
  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = $clog2(DIGITS);
  localparam int HALF_W = (SHCP_HALF > 1) ? $clog2(SHCP_HALF) : 1;
  localparam int BIT_W  = $clog2(FB);

  // ---------------------------------------------------------------------------
  // Load capture and BCD conversion
  // ---------------------------------------------------------------------------
  logic              conv_start;
  logic              conv_busy;
  logic              conv_done;
  logic              conv_lost;
  logic [4*NDIG-1:0] conv_bcd;
  logic [DIGITS-1:0] pt_q;
  logic              sign_q;

  assign conv_start = data_vld && !conv_busy;

  always_ff @(posedge sys_clk) begin
    if (conv_start) begin
      pt_q   <= point;
      sign_q <= sign;
    end
  end

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .NDIG   (NDIG)
  ) u_bin2bcd (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .start (conv_start),
    .bin   (data),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .lost  (conv_lost)
  );

  // ---------------------------------------------------------------------------
  // Digit encoder: blanking, sign, points, overflow (active-low codes)
  // ---------------------------------------------------------------------------
  logic [DIGITS-1:0][7:0] enc_seg;
  logic                   enc_ovf;
  int                     top_idx;

  always_comb begin
    enc_seg = {DIGITS{SEG_BLANK}};
    enc_ovf = 1'b0;
    top_idx = 0;
    // Highest digit that must be shown: a non-zero digit or a lit point.
    for (int i = 0; i < DIGITS; i++) begin
      if ((conv_bcd[4*i +: 4] != 4'd0) || pt_q[i]) top_idx = i;
    end
    // No room for the minus when the span already fills the display.
    enc_ovf = conv_lost || (conv_bcd[4*DIGITS +: 4] != 4'd0) ||
              (sign_q && (top_idx == DIGITS - 1));
    for (int i = 0; i < DIGITS; i++) begin
      if (enc_ovf) begin
        enc_seg[i] = SEG_MINUS;
      end else if (i <= top_idx) begin
        enc_seg[i] = seg_code(conv_bcd[4*i +: 4]);
        if (pt_q[i]) enc_seg[i][7] = 1'b0;
      end else if (sign_q && (i == top_idx + 1)) begin
        enc_seg[i] = SEG_MINUS;
      end
    end
  end

  logic [DIGITS-1:0][7:0] disp_q;
  logic                   ovf_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      disp_q <= {DIGITS{SEG_BLANK}};
      ovf_q  <= 1'b0;
    end else if (conv_done) begin
      disp_q <= enc_seg;
      ovf_q  <= enc_ovf;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan slot counter and digit index
  // ---------------------------------------------------------------------------
  logic [SLOT_W-1:0] slot_cnt;
  logic [IDX_W-1:0]  scan_idx;
  logic              slot_start;

  assign slot_start = (slot_cnt == '0);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      slot_cnt <= '0;
      scan_idx <= '0;
    end else if (slot_cnt == SLOT_W'(SCAN_DIV - 1)) begin
      slot_cnt <= '0;
      scan_idx <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  logic [7:0]        seg_cur;
  logic [DIGITS-1:0] sel_cur;
  logic [FB-1:0]     frame_word;

  always_comb begin
    seg_cur = disp_q[scan_idx];
    if (SEG_ACTIVE_LOW == 0) seg_cur = ~seg_cur;
    sel_cur = DIGITS'(1) << scan_idx;
    if (SEL_ACTIVE_LOW != 0) sel_cur = ~sel_cur;
    frame_word = {seg_cur, sel_cur};
  end

  // ---------------------------------------------------------------------------
  // Shift / latch sequencer
  // ---------------------------------------------------------------------------
  shift_state_t      state_q, state_nxt;
  logic [FB-1:0]     frame_q, frame_nxt;
  logic [BIT_W-1:0]  bit_q, bit_nxt;
  logic [HALF_W-1:0] half_q, half_nxt;
  logic              shcp_q, shcp_nxt;
  logic              stcp_q, stcp_nxt;
  logic              half_end;

  assign half_end = (half_q == HALF_W'(SHCP_HALF - 1));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      bit_q   <= '0;
      half_q  <= '0;
      shcp_q  <= 1'b0;
      stcp_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      frame_q <= frame_nxt;
      bit_q   <= bit_nxt;
      half_q  <= half_nxt;
      shcp_q  <= shcp_nxt;
      stcp_q  <= stcp_nxt;
    end
  end

  // The frame is snapshotted at slot start, so a display update mid-frame
  // only shows up in the next slot. ds is the MSB of the shifting snapshot.
  always_comb begin
    state_nxt = state_q;
    frame_nxt = frame_q;
    bit_nxt   = bit_q;
    half_nxt  = half_q;
    shcp_nxt  = shcp_q;
    stcp_nxt  = stcp_q;
    case (state_q)
      ST_IDLE: begin
        shcp_nxt = 1'b0;
        stcp_nxt = 1'b0;
        if (slot_start) begin
          frame_nxt = frame_word;
          bit_nxt   = '0;
          half_nxt  = '0;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!half_end) begin
          half_nxt = half_q + 1'b1;
        end else begin
          half_nxt = '0;
          if (!shcp_q) begin
            shcp_nxt = 1'b1;
          end else begin
            shcp_nxt = 1'b0;
            if (bit_q == BIT_W'(FB - 1)) begin
              stcp_nxt  = 1'b1;
              state_nxt = ST_LATCH;
            end else begin
              bit_nxt   = bit_q + 1'b1;
              frame_nxt = {frame_q[FB-2:0], 1'b0};
            end
          end
        end
      end
      ST_LATCH: begin
        shcp_nxt = 1'b0;
        if (!half_end) begin
          half_nxt = half_q + 1'b1;
        end else begin
          half_nxt  = '0;
          stcp_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        shcp_nxt  = 1'b0;
        stcp_nxt  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // PWM brightness on oe
  // ---------------------------------------------------------------------------
  logic [3:0] pwm_cnt;
  logic       oe_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pwm_cnt <= '0;
      oe_q    <= 1'b1;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      oe_q    <= !(seg_en && (pwm_cnt <= bright));
    end
  end

  assign busy = conv_busy;
  assign ovf  = ovf_q;
  assign shcp = shcp_q;
  assign stcp = stcp_q;
  assign ds   = frame_q[FB-1];
  assign oe   = oe_q;

endmodule

// File: tb/tb_seg595_scan_n.sv
// tb_seg595_scan_n: directed bench for seg595_scan_n. A monitor rebuilds each
// shifted frame from shcp/ds/stcp; expected frames come from a decimal model
// and are queued per scan slot, then compared as frames arrive.
module tb_seg595_scan_n;

  localparam int DIGITS  = 6;
  localparam int DATA_W  = 20;
  localparam int SD      = 64;
  localparam int HALF    = 2;
  localparam int SEG_AL  = 1;
  localparam int SEL_AL  = 0;
  localparam int FB      = 8 + DIGITS;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b0;
  logic              data_vld = 1'b0;
  logic [DATA_W-1:0] data = '0;
  logic [DIGITS-1:0] point = '0;
  logic              sign = 1'b0;
  logic              seg_en = 1'b1;
  logic [3:0]        bright = 4'd15;
  logic              busy, ovf, shcp, stcp, ds, oe;

  seg595_scan_n #(
    .DIGITS         (DIGITS),
    .DATA_W         (DATA_W),
    .SCAN_DIV       (SD),
    .SHCP_HALF      (HALF),
    .SEG_ACTIVE_LOW (SEG_AL),
    .SEL_ACTIVE_LOW (SEL_AL)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .data_vld (data_vld),
    .data     (data),
    .point    (point),
    .sign     (sign),
    .seg_en   (seg_en),
    .bright   (bright),
    .busy     (busy),
    .ovf      (ovf),
    .shcp     (shcp),
    .stcp     (stcp),
    .ds       (ds),
    .oe       (oe)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int            slot;
    logic [FB-1:0] word;
    int            nbits;
    int            stw;
  } frame_t;

  frame_t     cap_q[$];
  frame_t     exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] exp_seg [DIGITS];
  logic       exp_ovf;

  // Posedges since reset release; slot s starts on edge s*SD.
  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // Frame monitor, sampled on the falling edge.
  logic          prev_shcp = 1'b0, prev_stcp = 1'b0;
  logic [FB-1:0] mon_sh = '0;
  int            mon_bits = 0, mon_stw = 0;
  always @(negedge sys_clk) begin
    frame_t f;
    if (sys_rst) begin
      mon_bits  = 0;
      mon_stw   = 0;
      prev_shcp = 1'b0;
      prev_stcp = 1'b0;
      cap_q.delete();
    end else begin
      if (shcp && !prev_shcp) begin
        mon_sh   = {mon_sh[FB-2:0], ds};
        mon_bits = mon_bits + 1;
      end
      if (stcp) mon_stw = mon_stw + 1;
      if (!stcp && prev_stcp) begin
        f.word  = mon_sh;
        f.nbits = mon_bits;
        f.stw   = mon_stw;
        f.slot  = cyc / SD;
        cap_q.push_back(f);
        mon_bits = 0;
        mon_stw  = 0;
      end
      prev_shcp = shcp;
      prev_stcp = stcp;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Decimal reference: repeated division, then blanking/sign/points/overflow.
  task automatic model(input int unsigned v, input logic [DIGITS-1:0] pt, input logic sg);
    int          dg[DIGITS];
    int unsigned t;
    int unsigned lim;
    int          top;
    t   = v;
    lim = 1;
    for (int i = 0; i < DIGITS; i++) begin
      dg[i] = int'(t % 10);
      t     = t / 10;
      lim   = lim * 10;
    end
    top = 0;
    for (int i = 0; i < DIGITS; i++) if (dg[i] != 0 || pt[i]) top = i;
    exp_ovf = (v >= lim) || (sg && top == DIGITS - 1);
    for (int i = 0; i < DIGITS; i++) begin
      if (exp_ovf)                      exp_seg[i] = 8'hBF;
      else if (i <= top)                exp_seg[i] = pt[i] ? (seg_of(dg[i]) & 8'h7F) : seg_of(dg[i]);
      else if (sg && i == top + 1)      exp_seg[i] = 8'hBF;
      else                              exp_seg[i] = 8'hFF;
    end
  endtask

  // Queue the frames of the first DIGITS slots starting after the current edge.
  task automatic push_frames();
    frame_t            e;
    int                s0;
    int                d;
    logic [7:0]        s;
    logic [DIGITS-1:0] oh;
    s0 = (cyc + SD - 1) / SD;
    for (int k = 0; k < DIGITS; k++) begin
      d  = (s0 + k) % DIGITS;
      s  = (SEG_AL != 0) ? exp_seg[d] : ~exp_seg[d];
      oh = '0;
      oh[d] = 1'b1;
      if (SEL_AL != 0) oh = ~oh;
      e.slot  = s0 + k;
      e.word  = {s, oh};
      e.nbits = FB;
      e.stw   = HALF;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_frames();
    frame_t e, f;
    bit     got;
    int     w;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = 1'b0;
      w   = 0;
      while (!got && w < 4 * SD) begin
        if (cap_q.size() > 0) begin
          f = cap_q.pop_front();
          if (f.slot >= e.slot) got = 1'b1;
        end else begin
          @(negedge sys_clk);
          w++;
        end
      end
      chk($sformatf("frame_seen_s%0d", e.slot), 64'(got), 64'd1);
      if (got) begin
        chk($sformatf("frame_slot_s%0d", e.slot), 64'(f.slot), 64'(e.slot));
        chk($sformatf("frame_word_s%0d", e.slot), 64'(f.word), 64'(e.word));
        chk($sformatf("frame_bits_s%0d", e.slot), 64'(f.nbits), 64'(e.nbits));
        chk($sformatf("stcp_width_s%0d", e.slot), 64'(f.stw), 64'(e.stw));
      end
    end
  endtask

  // Strobe one value; optionally try a second strobe while busy.
  task automatic load(input int unsigned v, input logic [DIGITS-1:0] pt, input logic sg,
                      input bit inject);
    int n;
    model(v, pt, sg);
    @(negedge sys_clk);
    data     = DATA_W'(v);
    point    = pt;
    sign     = sg;
    data_vld = 1'b1;
    @(negedge sys_clk);
    data_vld = 1'b0;
    chk("busy_set", 64'(busy), 64'd1);
    n = 0;
    while (busy && n < 100) begin
      if (inject && n == 3) begin
        data     = DATA_W'(999);
        sign     = 1'b1;
        data_vld = 1'b1;
      end else begin
        data_vld = 1'b0;
      end
      @(negedge sys_clk);
      n++;
    end
    data_vld = 1'b0;
    chk("busy_cycles", 64'(n), 64'(DATA_W + 1));
    chk("ovf", 64'(ovf), 64'(exp_ovf));
    push_frames();
  endtask

  task automatic count_oe_low(input int ncyc, output int lows);
    lows = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (!oe) lows++;
      @(negedge sys_clk);
    end
  endtask

  initial begin
    int w;
    int lows;

    // Reset state
    #2 sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("rst_shcp", 64'(shcp), 64'd0);
    chk("rst_stcp", 64'(stcp), 64'd0);
    chk("rst_ds",   64'(ds),   64'd0);
    chk("rst_oe",   64'(oe),   64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovf",  64'(ovf),  64'd0);
    sys_rst = 1'b0;

    // Display content across patterns
    load(1234, 6'b000000, 1'b0, 1'b0);  check_frames();
    load(5, 6'b000100, 1'b1, 1'b0);     check_frames();
    load(1000000, 6'b000000, 1'b0, 1'b0); check_frames();
    load(0, 6'b000000, 1'b0, 1'b0);     check_frames();
    load(123456, 6'b000000, 1'b1, 1'b0); check_frames();
    load(7, 6'b100000, 1'b0, 1'b0);     check_frames();
    load(99999, 6'b000000, 1'b1, 1'b0); check_frames();
    load(1000000, 6'b000000, 1'b0, 1'b0);

    // Reset during a conversion and in the middle of a frame
    w = 0;
    while (!((cyc % SD) >= 8 && (cyc % SD) <= 16) && w < 200) begin
      @(negedge sys_clk);
      w++;
    end
    data     = DATA_W'(77);
    point    = '0;
    sign     = 1'b0;
    data_vld = 1'b1;
    @(negedge sys_clk);
    data_vld = 1'b0;
    @(negedge sys_clk);
    chk("busy_before_rst", 64'(busy), 64'd1);
    chk("ovf_before_rst",  64'(ovf),  64'd1);
    w = 0;
    while (!shcp && w < 4) begin
      @(negedge sys_clk);
      w++;
    end
    #2 sys_rst = 1'b1;
    #1;
    chk("arst_shcp", 64'(shcp), 64'd0);
    chk("arst_stcp", 64'(stcp), 64'd0);
    chk("arst_ds",   64'(ds),   64'd0);
    chk("arst_oe",   64'(oe),   64'd1);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_ovf",  64'(ovf),  64'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < DIGITS; i++) exp_seg[i] = 8'hFF;
    push_frames();
    check_frames();
    load(42, 6'b000000, 1'b0, 1'b1);    check_frames();

    // Brightness PWM and output enable
    bright = 4'd0;
    @(negedge sys_clk);
    count_oe_low(32, lows);
    chk("pwm_bright0", 64'(lows), 64'd2);
    bright = 4'd15;
    @(negedge sys_clk);
    count_oe_low(32, lows);
    chk("pwm_bright15", 64'(lows), 64'd32);
    bright = 4'd7;
    @(negedge sys_clk);
    count_oe_low(32, lows);
    chk("pwm_bright7", 64'(lows), 64'd16);
    bright = 4'd15;
    @(negedge sys_clk);
    chk("oe_on_before_disable", 64'(oe), 64'd0);
    seg_en = 1'b0;
    @(negedge sys_clk);
    chk("oe_disable_1cyc", 64'(oe), 64'd1);
    count_oe_low(16, lows);
    chk("oe_disabled_hold", 64'(lows), 64'd0);
    seg_en = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
